// File: rtl/mlp_core.sv
// mlp_core: sequential two-layer perceptron (N_IN -> N_HID ReLU -> 1 linear).
// Weights arrive over a valid/ready stream. The hidden weights are at
// h*N_IN+i and the N_HID output weights follow them. Each inference pass:
// HID (one MAC per cycle) -> OUT (one MAC per cycle) -> LOSS -> [UPD] -> DONE.
// Optional feature macro: MLP_TRAIN_EN adds the UPD state, in which the output
// weights take a shifted-gradient step after every pass.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   wload_valid_i/ready_o, data_i     weight load stream (accepted only in IDLE)
//   start_i, x_i, target_i            pass request, packed inputs, training target
//   busy_o, done_o, weights_valid_o   status; done_o pulses once per completed pass
//   y_o, loss_o                       network output and squared error, held until next pass
module mlp_core #(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned N_HID    = 8,
    parameter int unsigned X_W      = 4,
    parameter int unsigned W_W      = 8,
    parameter int unsigned H_W      = 10,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned LR_SHIFT = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wload_valid_i,
    output logic                     wload_ready_o,
    input  logic signed [W_W-1:0]    wload_data_i,
    input  logic                     start_i,
    input  logic [N_IN*X_W-1:0]      x_i,
    input  logic signed [ACC_W-1:0]  target_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     weights_valid_o,
    output logic signed [ACC_W-1:0]  y_o,
    output logic [2*ACC_W-1:0]       loss_o
);

    localparam int unsigned N_HW   = N_HID * N_IN;
    localparam int unsigned N_W    = N_HW + N_HID;
    localparam int unsigned AW     = $clog2(N_W);
    localparam int unsigned IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned JW     = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int unsigned HP_W   = X_W + 1 + W_W;
    localparam int unsigned HS_W   = HP_W + IW + 1;
    localparam int unsigned HACC_W = (HS_W > H_W + 1) ? HS_W : H_W + 2;
    localparam int unsigned OP_W   = H_W + 1 + W_W;
    localparam int unsigned OS_W   = OP_W + JW + 1;
    localparam int unsigned SUM_W  = (OS_W > ACC_W) ? OS_W : ACC_W + 1;
    localparam int unsigned ERR_W  = ACC_W + 1;
    localparam int unsigned SQ_W   = 2 * ERR_W;
    localparam int unsigned LOSS_W = 2 * ACC_W;
`ifdef MLP_TRAIN_EN
    localparam int unsigned UP_W   = ERR_W + H_W + 1;
    localparam int unsigned UD_W   = ((UP_W > W_W) ? UP_W : W_W) + 1;
`endif

    // Saturation bounds expressed at the width of the value being clamped.
    localparam logic signed [HACC_W-1:0] H_MAX = {{(HACC_W-H_W){1'b0}}, {H_W{1'b1}}};
    localparam logic signed [SUM_W-1:0]  Y_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0]  Y_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
`ifdef MLP_TRAIN_EN
    localparam logic signed [UD_W-1:0]   W_MAX = {{(UD_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
    localparam logic signed [UD_W-1:0]   W_MIN = {{(UD_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HID,
        S_OUT,
        S_LOSS,
        S_UPD,
        S_DONE
    } state_t;

    // ReLU followed by clamp to the unsigned activation range.
    function automatic logic [H_W-1:0] relu_sat(input logic signed [HACC_W-1:0] v);
        logic [H_W-1:0] r;
        if (v[HACC_W-1])   r = '0;
        else if (v > H_MAX) r = {H_W{1'b1}};
        else                r = v[H_W-1:0];
        return r;
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > Y_MAX)      r = Y_MAX[ACC_W-1:0];
        else if (v < Y_MIN) r = Y_MIN[ACC_W-1:0];
        else                r = v[ACC_W-1:0];
        return r;
    endfunction

`ifdef MLP_TRAIN_EN
    function automatic logic signed [W_W-1:0] sat_w(input logic signed [UD_W-1:0] v);
        logic signed [W_W-1:0] r;
        if (v > W_MAX)      r = W_MAX[W_W-1:0];
        else if (v < W_MIN) r = W_MIN[W_W-1:0];
        else                r = v[W_W-1:0];
        return r;
    endfunction
`endif

    state_t                  state;
    logic signed [W_W-1:0]   w_mem [N_W];
    logic [H_W-1:0]          h_act [N_HID];
    logic [N_IN*X_W-1:0]     x_q;
    logic signed [ACC_W-1:0] target_q;
    logic signed [ACC_W-1:0] y_q;
    logic [LOSS_W-1:0]       loss_q;
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           k_idx;
    logic [IW-1:0]           i_idx;
    logic [JW-1:0]           j_idx;
    logic signed [HACC_W-1:0] hacc;
    logic signed [SUM_W-1:0] ysum;
`ifdef MLP_TRAIN_EN
    logic signed [ERR_W-1:0] err_q;
`endif

    logic [X_W-1:0]          x_sel;
    logic signed [HP_W-1:0]  hprod;
    logic signed [HACC_W-1:0] hacc_next;
    logic [AW-1:0]           wo_addr;
    logic signed [OP_W-1:0]  oprod;
    logic signed [SUM_W-1:0] ysum_next;
    logic signed [ERR_W-1:0] err_c;
    logic signed [SQ_W-1:0]  sq_c;
    logic [LOSS_W-1:0]       loss_c;
`ifdef MLP_TRAIN_EN
    logic signed [UP_W-1:0]  uprod;
    logic signed [UP_W-1:0]  ushift;
    logic signed [UD_W-1:0]  unew;
`endif

    // Datapath: hidden MAC, output MAC, error/loss and optional weight step.
    always_comb begin
        x_sel     = x_q[i_idx*X_W +: X_W];
        hprod     = HP_W'($signed({1'b0, x_sel})) * HP_W'(w_mem[k_idx]);
        hacc_next = hacc + HACC_W'(hprod);
        wo_addr   = AW'(N_HW) + AW'(j_idx);
        oprod     = OP_W'($signed({1'b0, h_act[j_idx]})) * OP_W'(w_mem[wo_addr]);
        ysum_next = ysum + SUM_W'(oprod);
        err_c     = ERR_W'(y_q) - ERR_W'(target_q);
        sq_c      = SQ_W'(err_c) * SQ_W'(err_c);
        // The square is never negative, so any set bit above LOSS_W means overflow.
        loss_c    = (|sq_c[SQ_W-1:LOSS_W]) ? {LOSS_W{1'b1}} : sq_c[LOSS_W-1:0];
`ifdef MLP_TRAIN_EN
        uprod     = UP_W'(err_q) * UP_W'($signed({1'b0, h_act[j_idx]}));
        ushift    = uprod >>> LR_SHIFT;
        unew      = UD_W'(w_mem[wo_addr]) - UD_W'(ushift);
`endif
    end

    // Control FSM, storage and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            for (int n = 0; n < int'(N_W); n++) w_mem[n] <= '0;
            for (int n = 0; n < int'(N_HID); n++) h_act[n] <= '0;
            x_q             <= '0;
            target_q        <= '0;
            y_q             <= '0;
            loss_q          <= '0;
            wptr            <= '0;
            k_idx           <= '0;
            i_idx           <= '0;
            j_idx           <= '0;
            hacc            <= '0;
            ysum            <= '0;
`ifdef MLP_TRAIN_EN
            err_q           <= '0;
`endif
            wload_ready_o   <= 1'b1;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            weights_valid_o <= 1'b0;
            y_o             <= '0;
            loss_o          <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wload_valid_i) begin
                        w_mem[wptr] <= wload_data_i;
                        if (wptr == AW'(N_W - 1)) begin
                            wptr            <= '0;
                            weights_valid_o <= 1'b1;
                        end else begin
                            wptr <= wptr + AW'(1);
                        end
                    end
                    if (start_i && weights_valid_o) begin
                        x_q           <= x_i;
                        target_q      <= target_i;
                        hacc          <= '0;
                        ysum          <= '0;
                        k_idx         <= '0;
                        i_idx         <= '0;
                        j_idx         <= '0;
                        busy_o        <= 1'b1;
                        wload_ready_o <= 1'b0;
                        state         <= S_HID;
                    end
                end
                S_HID: begin
                    hacc  <= hacc_next;
                    k_idx <= k_idx + AW'(1);
                    if (i_idx == IW'(N_IN - 1)) begin
                        h_act[j_idx] <= relu_sat(hacc_next);
                        hacc         <= '0;
                        i_idx        <= '0;
                        if (j_idx == JW'(N_HID - 1)) begin
                            j_idx <= '0;
                            state <= S_OUT;
                        end else begin
                            j_idx <= j_idx + JW'(1);
                        end
                    end else begin
                        i_idx <= i_idx + IW'(1);
                    end
                end
                S_OUT: begin
                    ysum <= ysum_next;
                    if (j_idx == JW'(N_HID - 1)) begin
                        y_q   <= sat_acc(ysum_next);
                        j_idx <= '0;
                        state <= S_LOSS;
                    end else begin
                        j_idx <= j_idx + JW'(1);
                    end
                end
                S_LOSS: begin
                    loss_q <= loss_c;
`ifdef MLP_TRAIN_EN
                    err_q  <= err_c;
                    state  <= S_UPD;
`else
                    state  <= S_DONE;
`endif
                end
`ifdef MLP_TRAIN_EN
                S_UPD: begin
                    // Only output weights live at wo_addr; hidden weights are untouched.
                    w_mem[wo_addr] <= sat_w(unew);
                    if (j_idx == JW'(N_HID - 1)) begin
                        j_idx <= '0;
                        state <= S_DONE;
                    end else begin
                        j_idx <= j_idx + JW'(1);
                    end
                end
`endif
                S_DONE: begin
                    done_o        <= 1'b1;
                    y_o           <= y_q;
                    loss_o        <= loss_q;
                    busy_o        <= 1'b0;
                    wload_ready_o <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    busy_o        <= 1'b0;
                    wload_ready_o <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule
